// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 absorb/pad datapath.
// Holds lane geometry, rate selection, padding bytes and FSM states.
package sha3_pkg;

   localparam int LANE_W         = 64;
   localparam int LANE_BYTES     = LANE_W / 8;
   localparam int STATE_LANES    = 25;
   localparam int MAX_RATE_LANES = 18;

   localparam logic [7:0] DS_SUFFIX = 8'h06;
   localparam logic [7:0] PAD_END   = 8'h80;

   typedef enum logic [1:0] {
      MODE_224 = 2'd0,
      MODE_256 = 2'd1,
      MODE_384 = 2'd2,
      MODE_512 = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      XOR  = 2'd2,
      OUT  = 2'd3
   } state_e;

   // Rate in lanes for each digest size.
   function automatic logic [4:0] rate_lanes(input logic [1:0] m);
      logic [4:0] r;
      unique case (mode_e'(m))
         MODE_224: r = 5'd18;
         MODE_256: r = 5'd17;
         MODE_384: r = 5'd13;
         MODE_512: r = 5'd9;
         default:  r = 5'd18;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sha3_lane_mask.sv
// Keeps the first bytes_i bytes of a lane and drops the domain suffix
// right behind them. Ports: lane_i, bytes_i (0..8, >8 = 8), lane_o.
module sha3_lane_mask
   import sha3_pkg::*;
(
   input  logic [LANE_W-1:0] lane_i,
   input  logic [3:0]        bytes_i,
   output logic [LANE_W-1:0] lane_o
);

   logic [3:0] n;

   always_comb begin
      n = (bytes_i > 4'd8) ? 4'd8 : bytes_i;
      lane_o = '0;
      for (int k = 0; k < LANE_BYTES; k++) begin
         if (4'(k) < n)
            lane_o[8*k +: 8] = lane_i[8*k +: 8];
         else if (4'(k) == n)
            lane_o[8*k +: 8] = DS_SUFFIX;
      end
   end

endmodule

// File: rtl/sha3_absorb_pad.sv
// Lane-serial SHA3 absorb stage with pad10*1 and 0x06 domain suffix.
// Ports: clk/rst, mode, in_* lane stream, state_in, blk_* block out, busy.
module sha3_absorb_pad
   import sha3_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANE_W-1:0]             in_lane,
   input  logic                          in_last,
   input  logic [3:0]                    in_bytes,
   input  logic [STATE_LANES*LANE_W-1:0] state_in,
   output logic                          blk_valid,
   input  logic                          blk_ready,
   output logic [STATE_LANES*LANE_W-1:0] blk_o,
   output logic                          blk_final,
   output logic                          busy
);

   localparam int CW = 5;
   localparam int SW = STATE_LANES * LANE_W;

   localparam logic [1:0] ST_FILL = FILL;
   localparam logic [1:0] ST_PAD  = PAD;
   localparam logic [1:0] ST_XOR  = XOR;
   localparam logic [1:0] ST_OUT  = OUT;

   localparam logic [LANE_W-1:0] END_LANE =
      {PAD_END, {(LANE_W-8){1'b0}}};
   localparam logic [LANE_W-1:0] SFX_LANE =
      {{(LANE_W-8){1'b0}}, DS_SUFFIX};

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     rate_q, rate_d;
   logic [CW-1:0]     pad_idx_q, pad_idx_d;
   logic              pend_q, pend_d;
   logic              pp_q, pp_d;
   logic              msg_q, msg_d;
   logic [LANE_W-1:0] buf_q [MAX_RATE_LANES];
   logic [LANE_W-1:0] buf_d [MAX_RATE_LANES];
   logic [SW-1:0]     blk_q, blk_d;
   logic              fin_q, fin_d;
   logic              bv_q, bv_d;

   logic              accept;
   logic              first;
   logic [CW-1:0]     rate;
   logic [CW-1:0]     last_idx;
   logic [3:0]        bytes_c;
   logic              short_last;
   logic              at_end;
   logic [LANE_W-1:0] masked;
   logic [SW-1:0]     buf_flat;

   assign in_ready  = (state_q == ST_FILL);
   assign blk_valid = bv_q;
   assign blk_o     = blk_q;
   assign blk_final = fin_q;
   // msg_q keeps busy high between blocks of a multi-block message.
   assign busy = msg_q || (cnt_q != '0) || (state_q != ST_FILL);

   assign accept = in_valid && in_ready;
   assign first  = !busy;
   // The first lane of a message uses the rate it is latching.
   assign rate     = first ? rate_lanes(mode) : rate_q;
   assign last_idx = rate - 5'd1;
   assign at_end   = (cnt_q == last_idx);

   // Non-last lanes pass whole: treat them as 8 valid bytes.
   assign bytes_c = !in_last ? 4'd8
                  : (in_bytes > 4'd8) ? 4'd8 : in_bytes;
   assign short_last = in_last && (bytes_c != 4'd8);

   sha3_lane_mask u_mask (
      .lane_i  (in_lane),
      .bytes_i (bytes_c),
      .lane_o  (masked)
   );

   // Rate part of the buffer, capacity lanes forced to zero.
   always_comb begin
      buf_flat = '0;
      for (int i = 0; i < MAX_RATE_LANES; i++) begin
         if (CW'(i) < rate_q)
            buf_flat[i*LANE_W +: LANE_W] = buf_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rate_d    = rate_q;
      pad_idx_d = pad_idx_q;
      pend_d    = pend_q;
      pp_d      = pp_q;
      msg_d     = msg_q;
      blk_d     = blk_q;
      fin_d     = fin_q;
      bv_d      = bv_q;
      for (int i = 0; i < MAX_RATE_LANES; i++)
         buf_d[i] = buf_q[i];

      unique case (state_q)
         ST_FILL: begin
            if (accept) begin
               if (first) begin
                  rate_d = rate_lanes(mode);
                  msg_d  = 1'b1;
               end
               cnt_d = cnt_q + 5'd1;
               // Data write and end-of-pad OR land in one update.
               for (int i = 0; i < MAX_RATE_LANES; i++) begin
                  if (CW'(i) == cnt_q)
                     buf_d[i] = masked;
                  if (short_last && CW'(i) == last_idx)
                     buf_d[i] = buf_d[i] | END_LANE;
               end
               if (short_last) begin
                  state_d = ST_XOR;
                  pend_d  = 1'b1;
               end else if (in_last && !at_end) begin
                  state_d   = ST_PAD;
                  pad_idx_d = cnt_q + 5'd1;
               end else if (in_last) begin
                  // Full last lane fills the block: pad in a new one.
                  state_d = ST_XOR;
                  pend_d  = 1'b0;
                  pp_d    = 1'b1;
               end else if (at_end) begin
                  state_d = ST_XOR;
                  pend_d  = 1'b0;
               end
            end
         end
         ST_PAD: begin
            for (int i = 0; i < MAX_RATE_LANES; i++) begin
               if (CW'(i) == pad_idx_q)
                  buf_d[i] = buf_d[i] | SFX_LANE;
               if (CW'(i) == rate_q - 5'd1)
                  buf_d[i] = buf_d[i] | END_LANE;
            end
            state_d = ST_XOR;
            pend_d  = 1'b1;
         end
         ST_XOR: begin
            blk_d   = state_in ^ buf_flat;
            fin_d   = pend_q;
            bv_d    = 1'b1;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (blk_ready) begin
               bv_d  = 1'b0;
               cnt_d = '0;
               for (int i = 0; i < MAX_RATE_LANES; i++)
                  buf_d[i] = '0;
               if (pp_q) begin
                  pp_d      = 1'b0;
                  pad_idx_d = '0;
                  state_d   = ST_PAD;
               end else begin
                  state_d = ST_FILL;
                  if (fin_q)
                     msg_d = 1'b0;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FILL;
         cnt_q     <= '0;
         rate_q    <= 5'd18;
         pad_idx_q <= '0;
         pend_q    <= 1'b0;
         pp_q      <= 1'b0;
         msg_q     <= 1'b0;
         blk_q     <= '0;
         fin_q     <= 1'b0;
         bv_q      <= 1'b0;
         for (int i = 0; i < MAX_RATE_LANES; i++)
            buf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rate_q    <= rate_d;
         pad_idx_q <= pad_idx_d;
         pend_q    <= pend_d;
         pp_q      <= pp_d;
         msg_q     <= msg_d;
         blk_q     <= blk_d;
         fin_q     <= fin_d;
         bv_q      <= bv_d;
         for (int i = 0; i < MAX_RATE_LANES; i++)
            buf_q[i] <= buf_d[i];
      end
   end

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// Scoreboard bench for sha3_absorb_pad: byte-level SHA3 padding model,
// randomized messages, directed latency/backpressure/reset cases.
module tb_sha3_absorb_pad;

   logic          clk;
   logic          rst;
   logic [1:0]    mode;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_lane;
   logic          in_last;
   logic [3:0]    in_bytes;
   logic [1599:0] state_in;
   logic          blk_valid;
   logic          blk_ready;
   logic [1599:0] blk_o;
   logic          blk_final;
   logic          busy;

   sha3_absorb_pad dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_lane   (in_lane),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .state_in  (state_in),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_o     (blk_o),
      .blk_final (blk_final),
      .busy      (busy)
   );

   typedef struct {
      logic [1599:0] blk;
      bit            fin;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   bp_force = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout expected=event", nm);
   endtask

   // Reference: message bytes || 0x06 || 0* || 0x80 (last byte OR),
   // split into rate-sized blocks, each XORed onto the state.
   function automatic void model(input logic [1:0] m,
                                 input byte unsigned msg[$],
                                 input logic [1599:0] st);
      byte unsigned p[$];
      int   dig, r, nblk;
      exp_t e;
      dig = (m == 0) ? 28 : (m == 1) ? 32 : (m == 2) ? 48 : 64;
      r = 200 - 2 * dig;
      p = msg;
      p.push_back(8'h06);
      while (p.size() % r != 0) p.push_back(8'h00);
      p[p.size()-1] = p[p.size()-1] | 8'h80;
      nblk = p.size() / r;
      for (int b = 0; b < nblk; b++) begin
         e.blk = st;
         for (int k = 0; k < r; k++)
            e.blk[8*k +: 8] = e.blk[8*k +: 8] ^ p[b*r + k];
         e.fin = (b == nblk - 1);
         sb.push_back(e);
      end
   endfunction

   // Monitor: every cycle a block is shown, it must equal the head
   // of the scoreboard; it is retired on the handshake.
   always @(negedge clk) begin
      if (!rst && blk_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_blk actual=valid expected=idle");
         end else begin
            checks++;
            if (blk_o !== sb[0].blk) begin
               errors++;
               for (int i = 0; i < 25; i++) begin
                  if (blk_o[64*i +: 64] !== sb[0].blk[64*i +: 64]) begin
                     $display("FAIL blk_lane%0d actual=%h expected=%h", i,
                              blk_o[64*i +: 64], sb[0].blk[64*i +: 64]);
                     break;
                  end
               end
            end
            chk("blk_final", 64'(blk_final), 64'(sb[0].fin));
            chk("in_ready_in_out", 64'(in_ready), 64'd0);
            if (blk_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      blk_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         blk_ready = bp_force ? 1'b0 : ($urandom % 4 != 0);
      end
   end

   task automatic send_lane(input logic [1:0] m, input logic [63:0] l,
                            input bit last, input logic [3:0] nb,
                            input bit gaps);
      bit acc;
      acc = 0;
      if (gaps && $urandom % 4 == 0) begin
         in_valid = 0;
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
      end
      mode = m;
      in_lane = l;
      in_last = last;
      in_bytes = nb;
      in_valid = 1;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) fail("lane_accept");
      in_valid = 0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (!busy && !blk_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail("wait_idle");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         cnt++;
         if (blk_valid) break;
      end
      if (!blk_valid) fail("wait_valid");
   endtask

   task automatic send_msg(input logic [1:0] m, input int n,
                           input logic [1599:0] st, input bit set_st,
                           input bit extra_ok, input bit gaps);
      byte unsigned msg[$];
      logic [63:0]  l;
      logic [3:0]   ib;
      int   nl, nb;
      bit   extra, last;
      if (set_st) begin
         wait_idle();
         state_in = st;
      end
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      model(m, msg, state_in);
      nl = (n == 0) ? 1 : (n + 7) / 8;
      extra = extra_ok && n > 0 && n % 8 == 0 && $urandom % 3 == 0;
      for (int j = 0; j < nl; j++) begin
         nb = (n - 8*j > 8) ? 8 : n - 8*j;
         l = {$urandom, $urandom};
         for (int k = 0; k < nb; k++) l[8*k +: 8] = msg[8*j + k];
         last = (j == nl - 1) && !extra;
         if (last)
            ib = (nb == 8 && $urandom % 3 == 0) ?
                 4'($urandom_range(9, 15)) : 4'(nb);
         else
            ib = 4'($urandom);
         send_lane((j == 0) ? m : 2'($urandom), l, last, ib, gaps);
      end
      if (extra)
         send_lane(2'($urandom), {$urandom, $urandom}, 1, 4'd0, gaps);
   endtask

   logic [1599:0] tmp;
   logic [1599:0] ones;
   logic [1599:0] rs;
   int lat;
   int hi;

   initial begin
      rst = 1;
      mode = 0;
      in_valid = 0;
      in_lane = '0;
      in_last = 0;
      in_bytes = '0;
      state_in = '0;
      ones = '1;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_blk_valid", 64'(blk_valid), 64'd0);
      chk("rst_blk_final", 64'(blk_final), 64'd0);
      chk("rst_blk_o_nz", 64'(|blk_o), 64'd0);
      @(posedge clk);
      #1;

      // Empty message, SHA3-256.
      send_msg(2'd1, 0, '0, 1, 0, 0);
      wait_valid(lat);
      chk("empty_latency", 64'(lat), 64'd2);
      chk("empty_lane0", blk_o[63:0], 64'h06);
      chk("empty_lane16", blk_o[16*64 +: 64], 64'h8000000000000000);
      chk("empty_final", 64'(blk_final), 64'd1);
      tmp = blk_o;
      tmp[63:0] = '0;
      tmp[16*64 +: 64] = '0;
      chk("empty_other_nz", 64'(|tmp), 64'd0);

      // 71 bytes, SHA3-512: single block ending in 0x86.
      send_msg(2'd3, 71, '0, 1, 0, 0);
      wait_valid(lat);
      chk("b71_latency", 64'(lat), 64'd2);
      chk("b71_lane8_b7", 64'(blk_o[8*64 + 56 +: 8]), 64'h86);
      chk("b71_final", 64'(blk_final), 64'd1);

      // 72 bytes, SHA3-512: data block then a pure pad block.
      send_msg(2'd3, 72, '0, 1, 0, 0);
      hi = 0;
      for (int t = 0; t < 200 && busy; t++) begin
         @(negedge clk);
         if (busy && in_ready) hi++;
      end
      chk("b72_ready_low", 64'(hi), 64'd0);

      // 64 bytes, SHA3-512: full last lane short of the block -> PAD.
      send_msg(2'd3, 64, '0, 1, 0, 0);
      wait_valid(lat);
      chk("b64_pad_latency", 64'(lat), 64'd3);

      // Capacity passthrough with an all-ones state, SHA3-224.
      send_msg(2'd0, 143, ones, 1, 0, 1);
      wait_valid(lat);
      chk("cap_ones", 64'(&blk_o[1599:18*64]), 64'd1);

      // Backpressure with a lane waiting at the input.
      wait_idle();
      bp_force = 1;
      send_msg(2'd2, 20, '0, 0, 0, 0);
      wait_valid(lat);
      in_lane = {$urandom, $urandom};
      in_last = 1;
      in_bytes = 4'd3;
      in_valid = 1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_blk_valid", 64'(blk_valid), 64'd1);
      end
      in_valid = 0;
      bp_force = 0;

      // Reset in the middle of a message.
      wait_idle();
      for (int j = 0; j < 5; j++)
         send_lane(2'd0, {$urandom, $urandom}, 0, 4'd8, 0);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_blk_valid", 64'(blk_valid), 64'd0);
      @(posedge clk);
      #1;
      send_msg(2'd1, 0, '0, 1, 0, 0);
      wait_valid(lat);
      chk("mrst_empty_latency", 64'(lat), 64'd2);
      chk("mrst_empty_lane0", blk_o[63:0], 64'h06);

      // Random messages, rates and states; some back to back.
      for (int q = 0; q < 40; q++) begin
         for (int i = 0; i < 50; i++) rs[32*i +: 32] = $urandom;
         send_msg(2'($urandom), $urandom_range(0, 300), rs,
                  $urandom % 2 == 0, 1, 1);
      end

      for (int t = 0; t < 5000 && sb.size() != 0; t++) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
